// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if
// Bundles everything that flows between the pipeline and the fetch-side
// PC redirect controller.
//   Requests (pipeline -> controller):
//     stall, br_valid, br_kind[1:0], br_pc, br_imm, rs1_val,
//     mem_redirect_valid, mem_redirect_pc, trap_req, trap_ret
//   Status (controller -> pipeline):
//     pc, pc_valid, flush_if_id, flush_id_ex, trap_active, trap_ack, epc
// The pipeline side uses the master modport; the controller uses slave.
interface pc_redirect_ctrl_if;
  logic        stall;
  logic        br_valid;
  logic [1:0]  br_kind;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] rs1_val;
  logic        mem_redirect_valid;
  logic [31:0] mem_redirect_pc;
  logic        trap_req;
  logic        trap_ret;

  logic [31:0] pc;
  logic        pc_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        trap_active;
  logic        trap_ack;
  logic [31:0] epc;

  modport master (
    output stall, br_valid, br_kind, br_pc, br_imm, rs1_val,
           mem_redirect_valid, mem_redirect_pc, trap_req, trap_ret,
    input  pc, pc_valid, flush_if_id, flush_id_ex, trap_active, trap_ack, epc
  );

  modport slave (
    input  stall, br_valid, br_kind, br_pc, br_imm, rs1_val,
           mem_redirect_valid, mem_redirect_pc, trap_req, trap_ret,
    output pc, pc_valid, flush_if_id, flush_id_ex, trap_active, trap_ack, epc
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Owns the fetch PC. Each cycle picks the next PC from (highest first):
// a parked redirect (released when not stalled), MEM redirect, trap entry,
// trap return, EX branch/JALR, sequential +4. While stalled the PC holds and
// one redirect is parked; a MEM redirect may replace a parked one, a branch
// never replaces a parked MEM redirect. Every accepted redirect produces one
// flush pulse on both pipeline flush outputs (at capture, not at release).
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    pc_redirect_ctrl_if.slave (requests in, pc/flush/trap status out)
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_03FC
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_redirect_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_is_mem_q, pend_is_mem_d;
  logic        flush_q, flush_d;
  logic        ack_q, ack_d;

  logic        br_ok;
  logic [31:0] jalr_sum;
  logic [31:0] br_target;

  // Kinds 00/11 are not control transfers at all: no redirect, no flush.
  assign br_ok     = bus.br_valid && (bus.br_kind == 2'b01 || bus.br_kind == 2'b10);
  assign jalr_sum  = bus.rs1_val + bus.br_imm;
  assign br_target = (bus.br_kind == 2'b10) ? {jalr_sum[31:2], 2'b00}
                                            : bus.br_pc + bus.br_imm;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_is_mem_q <= 1'b0;
      pend_pc_q     <= 32'h0;
      flush_q       <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state         <= state_next;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_valid_q  <= pend_valid_d;
      pend_is_mem_q <= pend_is_mem_d;
      pend_pc_q     <= pend_pc_d;
      flush_q       <= flush_d;
      ack_q         <= ack_d;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_next    = state;
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_valid_d  = pend_valid_q;
    pend_is_mem_d = pend_is_mem_q;
    pend_pc_d     = pend_pc_q;
    flush_d       = 1'b0;
    ack_d         = 1'b0;

    unique case (state)
      BOOT: state_next = RUN;
      default: begin
        if (bus.stall) begin
          // PC holds; park at most one redirect. A trap request simply
          // waits because it is a level and retries on a later cycle.
          if (bus.mem_redirect_valid) begin
            pend_valid_d  = 1'b1;
            pend_is_mem_d = 1'b1;
            pend_pc_d     = bus.mem_redirect_pc;
            flush_d       = 1'b1;
          end else if (br_ok && !(pend_valid_q && pend_is_mem_q)) begin
            pend_valid_d  = 1'b1;
            pend_is_mem_d = 1'b0;
            pend_pc_d     = br_target;
            flush_d       = 1'b1;
          end
        end else if (pend_valid_q) begin
          // Release: the flush already went out at capture time.
          pc_d          = pend_pc_q;
          pend_valid_d  = 1'b0;
          pend_is_mem_d = 1'b0;
        end else if (bus.mem_redirect_valid) begin
          pc_d    = bus.mem_redirect_pc;
          flush_d = 1'b1;
        end else if (state == RUN && bus.trap_req) begin
          // Return address is the not-yet-fetched current PC.
          epc_d      = pc_q;
          pc_d       = TRAP_VECTOR;
          state_next = TRAP;
          ack_d      = 1'b1;
          flush_d    = 1'b1;
        end else if (state == TRAP && bus.trap_ret) begin
          pc_d       = epc_q;
          state_next = RUN;
          flush_d    = 1'b1;
        end else if (br_ok) begin
          pc_d    = br_target;
          flush_d = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    endcase
  end

  // Outputs: decoded from the state register or driven straight from flops.
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_valid    = (state != BOOT);
    bus.trap_active = (state == TRAP);
    bus.flush_if_id = flush_q;
    bus.flush_id_ex = flush_q;
    bus.trap_ack    = ack_q;
    bus.epc         = epc_q;
  end

endmodule
